// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master round-robin arbiter and sequencer for the single-port
// data memory. Master 0 is the pipeline MEM stage and master 1 is the
// bridge/DMA port. Locked bursts are capped at BURST_MAX consecutive grants.
// Every access is range checked. Each grant produces a registered response
// one cycle later.
//
// Optional feature: define DM_ARB_ALIGN_CHK_EN to also reject a misaligned
// word access or a misaligned halfword access. The access size codes match
// DMOp_w and DMOp_h in const.v.
module dm_arbiter #(
  parameter int          BURST_MAX  = 4,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  // master 0
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_op,
  input  logic        m0_ext,
  input  logic [31:0] m0_pc,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  // master 1
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_op,
  input  logic        m1_ext,
  input  logic [31:0] m1_pc,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  // data memory port
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [1:0]  dm_op,
  output logic        dm_ext,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_e;

  // A locked owner may take this grant only while the count is below this value.
  localparam logic [2:0] BURST_LAST = 3'(BURST_MAX - 1);

`ifdef DM_ARB_ALIGN_CHK_EN
  localparam logic [1:0] DMOP_W = 2'd0;
  localparam logic [1:0] DMOP_H = 2'd1;
`endif

  owner_e      owner_q, owner_d;
  logic        last_q, last_d;
  logic [2:0]  burst_cnt_q, burst_cnt_d;
  logic        m0_rvalid_q, m0_rvalid_d;
  logic        m0_err_q, m0_err_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic        m1_err_q, m1_err_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        win_valid;
  logic        win_id;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_op;
  logic        sel_ext;
  logic [31:0] sel_pc;
  logic        reject;

  // Winner selection: a locked owner first, then round-robin, then a lone requester.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    win_valid = 1'b0;
    win_id    = 1'b0;
    if (owner_q == OWN0 && m0_req && m0_lock && burst_cnt_q < BURST_LAST) begin
      win_valid = 1'b1;
      win_id    = 1'b0;
    end else if (owner_q == OWN1 && m1_req && m1_lock && burst_cnt_q < BURST_LAST) begin
      win_valid = 1'b1;
      win_id    = 1'b1;
    end else if (m0_req && m1_req) begin
      win_valid = 1'b1;
      win_id    = ~last_q;
    end else if (m0_req || m1_req) begin
      win_valid = 1'b1;
      win_id    = m1_req;
    end
  end

  // Route the winner's access to the DM port and range/alignment check it.
  always_comb begin
    sel_we    = win_id ? m1_we    : m0_we;
    sel_addr  = win_id ? m1_addr  : m0_addr;
    sel_wdata = win_id ? m1_wdata : m0_wdata;
    sel_op    = win_id ? m1_op    : m0_op;
    sel_ext   = win_id ? m1_ext   : m0_ext;
    sel_pc    = win_id ? m1_pc    : m0_pc;

    reject = (sel_addr >= ADDR_LIMIT);
`ifdef DM_ARB_ALIGN_CHK_EN
    if (sel_op == DMOP_W && sel_addr[1:0] != 2'b00) reject = 1'b1;
    if (sel_op == DMOP_H && sel_addr[0])            reject = 1'b1;
`endif

    m0_gnt  = win_valid && !win_id;
    m1_gnt  = win_valid &&  win_id;
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_wd   = '0;
    dm_op   = '0;
    dm_ext  = 1'b0;
    dm_pc   = '0;
    if (win_valid) begin
      // A rejected store never writes, and reset low blocks the write.
      dm_we   = sel_we && !reject && reset;
      dm_addr = sel_addr;
      dm_wd   = sel_wdata;
      dm_op   = sel_op;
      dm_ext  = sel_ext;
      dm_pc   = sel_pc;
    end
  end

  // Next ownership, burst count and the responses returned to each master.
  always_comb begin
    owner_d     = IDLE;
    last_d      = last_q;
    burst_cnt_d = 3'd0;
    if (win_valid) begin
      owner_d = win_id ? OWN1 : OWN0;
      last_d  = win_id;
      if (owner_q == owner_d)
        burst_cnt_d = (burst_cnt_q < BURST_LAST) ? burst_cnt_q + 3'd1 : burst_cnt_q;
    end

    m0_rvalid_d = m0_gnt;
    m0_err_d    = m0_gnt && reject;
    m0_rdata_d  = (m0_gnt && !sel_we && !reject) ? dm_rd : 32'd0;
    m1_rvalid_d = m1_gnt;
    m1_err_d    = m1_gnt && reject;
    m1_rdata_d  = (m1_gnt && !sel_we && !reject) ? dm_rd : 32'd0;
  end

  // State and response registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= 3'd0;
      m0_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m0_rdata_q  <= 32'd0;
      m1_rvalid_q <= 1'b0;
      m1_err_q    <= 1'b0;
      m1_rdata_q  <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m0_err_q    <= m0_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rvalid_q <= m1_rvalid_d;
      m1_err_q    <= m1_err_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m0_err    = m0_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m1_err    = m1_err_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
